pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised valid/ready pipeline stage register.
//
// Carries a CTRL_W control bundle and a DATA_W operand bundle between two
// datapath stages. A main entry (M) drives the outputs; a skid entry (S)
// catches the one beat that can arrive while downstream stalls, so the stage
// sustains one beat per cycle with in_ready driven purely from a register.
//
// Ports:
//   CLK_PReg    clock, rising edge
//   RST_PReg    synchronous reset, active-low (wins over everything)
//   CLR_PReg    synchronous flush, active-high (empties both entries)
//   in_valid / in_ready / in_ctrl / in_data      upstream handshake + payload
//   out_valid / out_ready / out_ctrl / out_data  downstream handshake + payload
//   occ         number of valid entries, 0..2
//
// Optional feature, macro PSR_PERF_CNT_EN:
//   stall_cnt   saturating count of cycles with out_valid=1 and out_ready=0
//   bubble_cnt  saturating count of flush cycles that found a non-empty stage
module pipe_stage_reg #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 111,
    parameter int CNT_W  = 16
) (
    input  logic              CLK_PReg,
    input  logic              RST_PReg,
    input  logic              CLR_PReg,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
`ifdef PSR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic              mainVld, skidVld;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic [DATA_W-1:0] mainData, skidData;
    logic              inFire, outFire;

    assign in_ready  = !skidVld;
    assign out_valid = mainVld;
    assign out_ctrl  = mainCtrl;
    assign out_data  = mainData;
    assign occ       = {1'b0, mainVld} + {1'b0, skidVld};

    assign inFire  = in_valid & !skidVld;
    assign outFire = mainVld & out_ready;

    always_ff @(posedge CLK_PReg) begin
        if (!RST_PReg || CLR_PReg) begin
            mainVld  <= 1'b0;
            skidVld  <= 1'b0;
            mainCtrl <= '0;
            mainData <= '0;
            skidCtrl <= '0;
            skidData <= '0;
        end else if (skidVld) begin
            // Skid full: upstream is blocked, only a drain can move state.
            // The skid entry only fills while main is valid, so main stays valid.
            if (outFire) begin
                mainCtrl <= skidCtrl;
                mainData <= skidData;
                skidVld  <= 1'b0;
            end
        end else if (inFire && (!mainVld || outFire)) begin
            mainVld  <= 1'b1;
            mainCtrl <= in_ctrl;
            mainData <= in_data;
        end else if (inFire) begin
            // Main is stalled: park the new beat in the skid entry.
            skidVld  <= 1'b1;
            skidCtrl <= in_ctrl;
            skidData <= in_data;
        end else if (outFire) begin
            // Payload left stale; it is invisible once out_valid drops.
            mainVld <= 1'b0;
        end
    end

`ifdef PSR_PERF_CNT_EN
    // Counters observe pre-edge state and ignore flush; only reset clears them.
    always_ff @(posedge CLK_PReg) begin
        if (!RST_PReg) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (mainVld && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (CLR_PReg && (mainVld || skidVld) && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int CTRL_W = 10;
    localparam int DATA_W = 111;
    localparam int PW     = CTRL_W + DATA_W;

    logic              clk = 1'b0;
    logic              rstN, clr;
    logic              inValid, inReady;
    logic [CTRL_W-1:0] inCtrl;
    logic [DATA_W-1:0] inData;
    logic              outValid, outReady;
    logic [CTRL_W-1:0] outCtrl;
    logic [DATA_W-1:0] outData;
    logic [1:0]        occ;

    int nChecks = 0;
    int nPass   = 0;

    logic [PW-1:0] sbq[$];

    always #5 clk = ~clk;

`ifdef PSR_PERF_CNT_EN
    logic [15:0] stallCnt, bubbleCnt;
    logic [1:0]  stallCnt2, bubbleCnt2;
    logic              outValid2, inReady2;
    logic [CTRL_W-1:0] outCtrl2;
    logic [DATA_W-1:0] outData2;
    logic [1:0]        occ2;
`endif

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .CLK_PReg(clk), .RST_PReg(rstN), .CLR_PReg(clr),
        .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
        .occ(occ)
`ifdef PSR_PERF_CNT_EN
        , .stall_cnt(stallCnt), .bubble_cnt(bubbleCnt)
`endif
    );

`ifdef PSR_PERF_CNT_EN
    // Narrow-counter copy fed by the same stimulus to observe saturation.
    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(2)) dut2 (
        .CLK_PReg(clk), .RST_PReg(rstN), .CLR_PReg(clr),
        .in_valid(inValid), .in_ready(inReady2), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid2), .out_ready(outReady), .out_ctrl(outCtrl2), .out_data(outData2),
        .occ(occ2), .stall_cnt(stallCnt2), .bubble_cnt(bubbleCnt2)
    );
`endif

    function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    function automatic logic [CTRL_W-1:0] mkCtrl(input logic [DATA_W-1:0] d);
        return d[CTRL_W-1:0] ^ 10'h155;
    endfunction

    task automatic drive(input bit v, input logic [DATA_W-1:0] d);
        inValid = v;
        inData  = d;
        inCtrl  = mkCtrl(d);
    endtask

    // One clock: record an accepted beat at the negedge, then land #1 after the edge.
    task automatic step();
        @(negedge clk);
        if (rstN && !clr && inValid && inReady) sbq.push_back({inCtrl, inData});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream transfer must match the oldest accepted beat.
    always @(negedge clk) begin
        if (rstN && outValid && outReady) begin
            if (sbq.size() == 0) begin
                nChecks++;
                $display("FAIL out_unexpected: got %0h expected nothing", outData);
            end else begin
                check("out_beat", {outCtrl, outData}, sbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstN = 1'b0; clr = 1'b0; outReady = 1'b0;
        inValid = 1'b1; inData = '0; inCtrl = 10'h3FF;

        // Reset dominates a live input.
        step(); step();
        check("rst_out_valid", outValid, 0);
        check("rst_out_ctrl", outCtrl, 0);
        check("rst_out_data", outData, 0);
        check("rst_in_ready", inReady, 1);
        check("rst_occ", occ, 0);
        rstN = 1'b1;
        drive(0, '0);

        // Full-rate stream: each beat appears the cycle after it is sent.
        outReady = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            drive(1, DATA_W'(d));
            step();
            check("stream_in_ready", inReady, 1);
            check("stream_occ", occ, 1);
            check("stream_data", outData, d);
        end
        drive(0, '0);
        step();
        check("stream_empty", occ, 0);

        // Backpressure: A in main, B in skid, C held off.
        outReady = 1'b0;
        drive(1, 'hA); step();
        drive(1, 'hB); step();
        drive(1, 'hC); step();
        check("bp_occ", occ, 2);
        check("bp_in_ready", inReady, 0);
        check("bp_hold_a", outData, 'hA);
        step();
        check("bp_hold_a2", outData, 'hA);
        check("bp_hold_ctrl", outCtrl, mkCtrl('hA));
        outReady = 1'b1;
        step();                     // A leaves, B moves to main
        check("bp_b_main", outData, 'hB);
        check("bp_ready_back", inReady, 1);
        step();                     // C accepted while B leaves
        drive(0, '0);
        for (int i = 0; i < 10 && occ != 0; i++) step();
        check("bp_drained", occ, 0);
        check("bp_no_loss", sbq.size(), 0);

        // Flush while full discards both entries and the incoming beat.
        outReady = 1'b0;
        drive(1, 'h11); step();
        drive(1, 'h12); step();
        check("fl_full", occ, 2);
        drive(1, 'hD); clr = 1'b1;
        step();
        clr = 1'b0; drive(0, '0);
        sbq.delete();
        check("fl_occ", occ, 0);
        check("fl_out_valid", outValid, 0);
        check("fl_out_ctrl", outCtrl, 0);
        check("fl_out_data", outData, 0);
        check("fl_in_ready", inReady, 1);
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_no_d", outValid, 0);
        end

        // Simultaneous in/out fire with an empty skid replaces main.
        drive(1, 'h21); step();
        drive(1, 'h22); step();
        check("sim_occ", occ, 1);
        check("sim_main", outData, 'h22);
        outReady = 1'b0;
        drive(1, 'h23); step();
        check("sim_skid_occ", occ, 2);
        drive(0, '0); outReady = 1'b1;
        step();
        check("sim_m_from_s", outData, 'h23);
        check("sim_in_ready", inReady, 1);
        check("sim_occ1", occ, 1);
        step();
        check("sim_empty", occ, 0);

        // Reset mid-stream while full.
        outReady = 1'b0;
        drive(1, 'h31); step();
        drive(1, 'h32); step();
        check("mr_full", occ, 2);
        drive(0, '0); rstN = 1'b0;
        step();
        check("mr_occ", occ, 0);
        check("mr_out_valid", outValid, 0);
        rstN = 1'b1;
        sbq.delete();

`ifdef PSR_PERF_CNT_EN
        // Counters were cleared by the reset above.
        drive(1, 'h41); step();
        drive(0, '0);
        for (int i = 0; i < 6; i++) step();
        check("pc_stall", stallCnt, 6);
        check("pc_stall_sat", stallCnt2, 3);
        outReady = 1'b1; clr = 1'b1; step();
        clr = 1'b0; outReady = 1'b0;
        drive(1, 'h42); step();
        drive(0, '0);
        outReady = 1'b1; clr = 1'b1; step();
        clr = 1'b0;
        check("pc_bubble", bubbleCnt, 2);
        check("pc_bubble2", bubbleCnt2, 2);
        check("pc_stall_hold", stallCnt, 6);
        step();
`endif

        check("sb_empty_end", sbq.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
